exe_stage: RTL and testbench

Execute pipeline stage of the LoongArch scalar core. Sits between decode and memory stages. Latches one decoded instruction from decode, drives the `alu` instance (19-bit one-hot op, multi-cycle divider), holds until the ALU signals completion, and hands the result to the memory stage. Also issues the data-SRAM request and exports a forwarding/hazard port back to decode.

---
 rtl/exe_stage.sv | 217 +++++++++++++++++++++
 tb/tb_exe_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage -- execute pipeline stage of the LoongArch scalar core.
//
// Holds one decoded instruction between decode and memory. It drives the
// alu (19-bit one-hot op, multi-cycle divider), waits for alu completion,
// offers the result to the memory stage, issues the data-SRAM request in the
// handoff cycle and exports a forwarding/hazard port back to decode.
//
// Ports:
//   clk, resetn          core clock (rising edge), async active-low reset
//   ds_to_es_valid/bus   instruction offered by decode (155 bits)
//   es_allowin           this stage can accept an instruction this cycle
//   ms_allowin           memory stage can accept
//   es_to_ms_valid/bus   result offered to memory (71 bits)
//   flush                kills the held instruction and any load this cycle
//   data_sram_*          data request: en, we[3:0], addr, wdata
//   es_fwd_*             forwarding valid/dest/data and decode stall request
//
// Configuration macro: EXE_FWD_EN -- when defined, the ALU result is
// forwarded to decode; otherwise decode stalls on every RAW hit.
//
// ALU op bit map (one-hot): 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or,
// 7 xor, 8 sll, 9 srl, 10 sra, 11 lui, 12 mul, 13 mulh, 14 mulhu, 15 div,
// 16 mod, 17 divu, 18 modu.
// ---------------------------------------------------------------------------
module alu (
  input  logic        clk,
  input  logic        resetn,
  input  logic [18:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  input  logic        div_ack,      // result taken; divider may restart
  output logic [31:0] alu_result,
  output logic        alu_complete
);
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  div_state_e  r_state;
  logic [31:0] r_rem, r_quo, r_dvs;
  logic [4:0]  r_cnt;
  logic        r_neg_q, r_neg_r;

  logic        w_div_op, w_div_signed;
  logic [31:0] w_sum, w_diff_ab, w_a_abs, w_b_abs, w_quo, w_rem;
  logic [63:0] w_ma, w_mb, w_prod;
  logic [32:0] w_shift;
  logic [33:0] w_trial;
  logic        w_fits;

  assign w_div_op     = |alu_op[18:15];
  assign w_div_signed = alu_op[15] | alu_op[16];

  assign w_sum     = alu_src1 + alu_src2;
  assign w_diff_ab = alu_src1 - alu_src2;

  // One 64-bit multiplier: sign-extend only for mulh, so the low 64 bits of
  // the product are right for mul, mulh and mulhu alike.
  assign w_ma   = {{32{alu_op[13] & alu_src1[31]}}, alu_src1};
  assign w_mb   = {{32{alu_op[13] & alu_src2[31]}}, alu_src2};
  assign w_prod = w_ma * w_mb;

  // Restoring divider on magnitudes; signs are re-applied at the output.
  assign w_a_abs = (w_div_signed & alu_src1[31]) ? -alu_src1 : alu_src1;
  assign w_b_abs = (w_div_signed & alu_src2[31]) ? -alu_src2 : alu_src2;
  assign w_shift = {r_rem, r_quo[31]};
  assign w_trial = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_fits  = ~w_trial[33];
  assign w_quo   = r_neg_q ? -r_quo : r_quo;
  assign w_rem   = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // the pre-edge values regardless of statement order.
    if (!resetn) begin
      r_state <= DIV_IDLE;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (!w_div_op) begin
      // A zero/non-divide op abandons any divide in flight.
      r_state <= DIV_IDLE;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          r_rem   <= '0;
          r_quo   <= w_a_abs;
          r_dvs   <= w_b_abs;
          r_cnt   <= '0;
          r_neg_q <= w_div_signed & (alu_src1[31] ^ alu_src2[31]);
          r_neg_r <= w_div_signed & alu_src1[31];
          r_state <= DIV_BUSY;
        end
        DIV_BUSY: begin
          r_rem   <= w_fits ? w_trial[31:0] : w_shift[31:0];
          r_quo   <= {r_quo[30:0], w_fits};
          r_cnt   <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= DIV_DONE;
        end
        default: if (div_ack) r_state <= DIV_IDLE;
      endcase
    end
  end

  assign alu_complete = ~w_div_op | (r_state == DIV_DONE);

  // One-hot op: OR of masked terms, so a zero op yields a zero result.
  assign alu_result =
      ({32{alu_op[0]}}  & w_sum)
    | ({32{alu_op[1]}}  & w_diff_ab)
    | ({32{alu_op[2]}}  & {31'b0, $signed(alu_src1) < $signed(alu_src2)})
    | ({32{alu_op[3]}}  & {31'b0, alu_src1 < alu_src2})
    | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
    | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
    | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
    | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
    | ({32{alu_op[8]}}  & (alu_src1 << alu_src2[4:0]))
    | ({32{alu_op[9]}}  & (alu_src1 >> alu_src2[4:0]))
    | ({32{alu_op[10]}} & 32'($signed(alu_src1) >>> alu_src2[4:0]))
    | ({32{alu_op[11]}} & alu_src2)
    | ({32{alu_op[12]}} & w_prod[31:0])
    | ({32{alu_op[13] | alu_op[14]}} & w_prod[63:32])
    | ({32{alu_op[15] | alu_op[17]}} & w_quo)
    | ({32{alu_op[16] | alu_op[18]}} & w_rem);
endmodule

module exe_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ds_to_es_valid,
  output logic         es_allowin,
  input  logic [154:0] ds_to_es_bus,
  input  logic         ms_allowin,
  output logic         es_to_ms_valid,
  output logic [70:0]  es_to_ms_bus,
  input  logic         flush,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic         es_fwd_valid,
  output logic [4:0]   es_fwd_dest,
  output logic [31:0]  es_fwd_data,
  output logic         es_fwd_blk
);
  typedef struct packed {
    logic [31:0] pc;
    logic [18:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] st_data;
    logic [4:0]  dest;
    logic        gr_we;
    logic        mem_re;
    logic        mem_we;
  } ds_bus_t;

  logic        r_es_valid;
  ds_bus_t     r_bus;
  logic [18:0] w_alu_op;
  logic [31:0] w_alu_result;
  logic        w_alu_complete, w_ready_go, w_dest_nz;

  assign w_ready_go = w_alu_complete;
  assign es_allowin = ~r_es_valid | (w_ready_go & ms_allowin);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_es_valid <= 1'b0;
      r_bus      <= '0;
    end else if (flush) begin
      r_es_valid <= 1'b0;
    end else if (es_allowin) begin
      r_es_valid <= ds_to_es_valid;
      if (ds_to_es_valid) r_bus <= ds_to_es_bus;
    end
  end

  // Bubbles and flushed slots present op 0, which also stops the divider.
  assign w_alu_op = (r_es_valid & ~flush) ? r_bus.alu_op : '0;

  alu u_alu (
    .clk          (clk),
    .resetn       (resetn),
    .alu_op       (w_alu_op),
    .alu_src1     (r_bus.src1),
    .alu_src2     (r_bus.src2),
    .div_ack      (es_to_ms_valid & ms_allowin),
    .alu_result   (w_alu_result),
    .alu_complete (w_alu_complete)
  );

  assign es_to_ms_valid = r_es_valid & w_ready_go & ~flush;
  assign es_to_ms_bus   = {r_bus.pc, w_alu_result, r_bus.dest, r_bus.gr_we, r_bus.mem_re};

  // Gated by ms_allowin so a stalled memory op requests only in its handoff cycle.
  assign data_sram_en    = r_es_valid & (r_bus.mem_re | r_bus.mem_we) & w_ready_go
                         & ms_allowin & ~flush;
  assign data_sram_we    = {4{data_sram_en & r_bus.mem_we}};
  assign data_sram_addr  = w_alu_result;
  assign data_sram_wdata = r_bus.st_data;

  assign w_dest_nz   = |r_bus.dest;
  assign es_fwd_dest = r_bus.dest;
`ifdef EXE_FWD_EN
  // Loads and unfinished divides have no usable result yet.
  assign es_fwd_valid = r_es_valid & r_bus.gr_we & ~r_bus.mem_re & w_ready_go & w_dest_nz;
  assign es_fwd_blk   = r_es_valid & r_bus.gr_we & w_dest_nz & (r_bus.mem_re | ~w_ready_go);
  assign es_fwd_data  = w_alu_result;
`else
  assign es_fwd_valid = 1'b0;
  assign es_fwd_blk   = r_es_valid & r_bus.gr_we & w_dest_nz;
  assign es_fwd_data  = '0;
`endif
endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;
  localparam int OP_ADD = 0, OP_SUB = 1, OP_SLT = 2, OP_AND = 4, OP_SLL = 8,
                 OP_MUL = 12, OP_DIV = 15, OP_MOD = 16, OP_DIVU = 17, OP_MODU = 18;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ds_to_es_valid;
  logic         es_allowin;
  logic [154:0] ds_to_es_bus;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic         flush;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         es_fwd_valid;
  logic [4:0]   es_fwd_dest;
  logic [31:0]  es_fwd_data;
  logic         es_fwd_blk;

  typedef struct packed {
    logic [70:0] bus;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] tb_pc    = 32'h1c00_0000;

  exe_stage dut (
    .clk(clk), .resetn(resetn),
    .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin), .ds_to_es_bus(ds_to_es_bus),
    .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .flush(flush),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .es_fwd_valid(es_fwd_valid), .es_fwd_dest(es_fwd_dest),
    .es_fwd_data(es_fwd_data), .es_fwd_blk(es_fwd_blk)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Offer one instruction; returns 1ns after the edge that captured it.
  task automatic issue(input int op_idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] st, input logic [4:0] dest, input logic gr_we,
                       input logic mem_re, input logic mem_we, input logic [31:0] exp_res,
                       input bit push);
    int          waited = 0;
    logic [18:0] op;
    exp_t        e;
    op = 19'd1 << op_idx;
    ds_to_es_bus   = {tb_pc, op, a, b, st, dest, gr_we, mem_re, mem_we};
    ds_to_es_valid = 1'b1;
    @(negedge clk);
    while (!es_allowin && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("issue_accept", 72'(es_allowin), 72'(1));
    if (push) begin
      e.bus   = {tb_pc, exp_res, dest, gr_we, mem_re};
      e.en    = mem_re | mem_we;
      e.we    = {4{mem_we}};
      e.addr  = exp_res;
      e.wdata = st;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
    tb_pc += 32'd4;
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("drain", 72'(sb.size()), 72'(0));
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handoff must match the oldest expected entry; no SRAM
  // request may appear outside a handoff.
  always @(negedge clk) begin
    if (resetn) begin
      if (es_to_ms_valid && ms_allowin) begin
        if (sb.size() == 0) check("unexpected_handoff", 72'(es_to_ms_valid), 72'(0));
        else begin
          m_e = sb.pop_front();
          check("handoff_bus", 72'(es_to_ms_bus), 72'(m_e.bus));
          check("handoff_sram", 72'({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata}),
                72'({m_e.en, m_e.we, m_e.addr, m_e.wdata}));
        end
      end else begin
        check("sram_idle", 72'(data_sram_en), 72'(0));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_allowin"}, 72'(es_allowin), 72'(1));
    check({tag, "_valid"}, 72'(es_to_ms_valid), 72'(0));
    check({tag, "_bus"}, 72'(es_to_ms_bus), 72'(0));
    check({tag, "_sram"}, 72'({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata}), 72'(0));
    check({tag, "_fwd"}, 72'({es_fwd_valid, es_fwd_dest, es_fwd_data, es_fwd_blk}), 72'(0));
    check({tag, "_alu_op"}, 72'(dut.w_alu_op), 72'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
    ms_allowin = 1'b1; flush = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    resetn = 1'b1;

    // add 5+7 -> 12, offered the cycle after capture, allowin stays high
    issue(OP_ADD, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 32'd12, 1'b1);
    @(negedge clk);
    check("add_offer", 72'(es_to_ms_valid), 72'(1));
    check("add_allowin", 72'(es_allowin), 72'(1));
`ifdef EXE_FWD_EN
    check("add_fwd", 72'({es_fwd_valid, es_fwd_blk, es_fwd_dest, es_fwd_data}), 72'({1'b1, 1'b0, 5'd3, 32'd12}));
`else
    check("add_fwd", 72'({es_fwd_valid, es_fwd_blk, es_fwd_dest, es_fwd_data}), 72'({1'b0, 1'b1, 5'd3, 32'd0}));
`endif
    @(posedge clk); #1;

    // back-to-back simple ops
    issue(OP_SUB, 32'd3, 32'd5, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 32'hffff_fffe, 1'b1);
    issue(OP_AND, 32'h0000_f0f0, 32'h0000_0ff0, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0000_00f0, 1'b1);
    issue(OP_SLT, 32'hffff_ffff, 32'd1, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 32'd1, 1'b1);
    issue(OP_SLL, 32'd1, 32'd4, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1);
    issue(OP_MUL, 32'd6, 32'd7, 32'd0, 5'd14, 1'b1, 1'b0, 1'b0, 32'd42, 1'b1);

    // divide 100/7 -> 14: stage blocks and requests a stall while waiting
    issue(OP_DIV, 32'd100, 32'd7, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd14, 1'b1);
    @(negedge clk);
    check("div_allowin", 72'(es_allowin), 72'(0));
    check("div_offer", 72'(es_to_ms_valid), 72'(0));
    check("div_blk", 72'(es_fwd_blk), 72'(1));
    drain();
    @(negedge clk);
    check("div_once", 72'(es_to_ms_valid), 72'(0));
    @(posedge clk); #1;

    issue(OP_DIV, 32'hffff_ff9c, 32'd7, 32'd0, 5'd10, 1'b1, 1'b0, 1'b0, 32'hffff_fff2, 1'b1);
    issue(OP_MOD, 32'd100, 32'd7, 32'd0, 5'd11, 1'b1, 1'b0, 1'b0, 32'd2, 1'b1);
    issue(OP_MOD, 32'hffff_ff9c, 32'd7, 32'd0, 5'd11, 1'b1, 1'b0, 1'b0, 32'hffff_fffe, 1'b1);
    issue(OP_DIVU, 32'hffff_ffff, 32'd2, 32'd0, 5'd12, 1'b1, 1'b0, 1'b0, 32'h7fff_ffff, 1'b1);
    issue(OP_MODU, 32'hffff_ffff, 32'd10, 32'd0, 5'd13, 1'b1, 1'b0, 1'b0, 32'd5, 1'b1);
    drain();

    // store under backpressure: no request until memory accepts, then one
    ms_allowin = 1'b0;
    issue(OP_ADD, 32'h1000_0000, 32'd4, 32'hdead_beef, 5'd0, 1'b0, 1'b0, 1'b1, 32'h1000_0004, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("st_hold", 72'({data_sram_en, es_to_ms_valid, es_allowin, data_sram_addr}),
            72'({1'b0, 1'b1, 1'b0, 32'h1000_0004}));
    end
    @(posedge clk); #1;
    ms_allowin = 1'b1;
    drain();

    // flush together with a new offer: the offer is dropped
    ds_to_es_bus   = {tb_pc, 19'd1, 32'd1, 32'd2, 32'd0, 5'd2, 3'b100};
    ds_to_es_valid = 1'b1;
    flush          = 1'b1;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    flush          = 1'b0;
    @(negedge clk);
    check("flush_drop", 72'({es_to_ms_valid, es_allowin}), 72'({1'b0, 1'b1}));
    @(posedge clk); #1;

    // flush 3 cycles into a divide, then 9/3 must be clean
    issue(OP_DIV, 32'd50, 32'd3, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd16, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_offer", 72'(es_to_ms_valid), 72'(0));
    check("flush_alu_op", 72'(dut.w_alu_op), 72'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_cleared", 72'({es_allowin, es_fwd_blk}), 72'({1'b1, 1'b0}));
    @(posedge clk); #1;
    issue(OP_DIV, 32'd9, 32'd3, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd3, 1'b1);
    drain();

    // async reset mid-divide
    issue(OP_DIV, 32'd100, 32'd7, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd14, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("rst_mid_div");
    @(posedge clk); #1;
    resetn = 1'b1;
    issue(OP_ADD, 32'd1, 32'd1, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 32'd2, 1'b1);
    drain();

    // load to r4 held by backpressure: must stall decode, never forward
    ms_allowin = 1'b0;
    issue(OP_ADD, 32'h0000_0100, 32'd4, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 1'b1);
    @(negedge clk);
    check("ld_fwd", 72'({es_fwd_blk, es_fwd_valid, es_fwd_dest}), 72'({1'b1, 1'b0, 5'd4}));
    @(posedge clk); #1;
    ms_allowin = 1'b1;
    // add to r0: neither forwards nor stalls
    issue(OP_ADD, 32'd3, 32'd4, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd7, 1'b1);
    @(negedge clk);
    check("r0_fwd", 72'({es_fwd_blk, es_fwd_valid}), 72'(0));
    drain();

    check("sb_empty", 72'(sb.size()), 72'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
